// File: rtl/prim_fault_ram_1p.sv
// Single-port RAM with per-channel read fault injection (bit flips on matching reads).
// Optional hit counter port flt_hits_o is built when PRIM_FAULT_RAM_STATS_EN is defined.
module prim_fault_ram_1p #(
  parameter int unsigned Width           = 32,
  parameter int unsigned Depth           = 128,
  parameter int unsigned NumFaults       = 2,
  parameter int unsigned OutputReg       = 0,
  parameter int unsigned DataBitsPerMask = 1,
  localparam int unsigned Aw = $clog2(Depth),
  localparam int unsigned Iw = (NumFaults > 1) ? $clog2(NumFaults) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic                 write_i,
  input  logic [Aw-1:0]        addr_i,
  input  logic [Width-1:0]     wdata_i,
  input  logic [Width-1:0]     wmask_i,
  output logic [Width-1:0]     rdata_o,
  output logic                 rvalid_o,
  input  logic                 flt_we_i,
  input  logic [Iw-1:0]        flt_idx_i,
  input  logic [Aw-1:0]        flt_addr_i,
  input  logic [Width-1:0]     flt_mask_i,
  input  logic [1:0]           flt_mode_i,
  input  logic [7:0]           flt_cnt_i,
  output logic [NumFaults-1:0] flt_armed_o
`ifdef PRIM_FAULT_RAM_STATS_EN
  ,
  output logic [15:0]          flt_hits_o
`endif
);

  typedef enum logic [1:0] {
    ModeOff     = 2'd0,
    ModeOneshot = 2'd1,
    ModeSticky  = 2'd2,
    ModeCount   = 2'd3
  } mode_e;

  logic [Width-1:0] mem [Depth];

  logic [Aw-1:0]        ch_addr_q [NumFaults];
  logic [Width-1:0]     ch_mask_q [NumFaults];
  mode_e                ch_mode_q [NumFaults];
  logic [7:0]           ch_cnt_q  [NumFaults];
  logic [NumFaults-1:0] armed_q;

  logic [Aw-1:0]        ch_addr_d [NumFaults];
  logic [Width-1:0]     ch_mask_d [NumFaults];
  mode_e                ch_mode_d [NumFaults];
  logic [7:0]           ch_cnt_d  [NumFaults];
  logic [NumFaults-1:0] armed_d;

  logic                 rd_req;
  logic                 in_range;
  logic [NumFaults-1:0] hit;
  logic [Width-1:0]     flip;
  logic [Width-1:0]     bit_en;
  logic [Width-1:0]     rd_word;

  logic                 s1_valid_q;
  logic [Width-1:0]     s1_data_q;

  // Decode the access and evaluate triggers against the current channel configuration.
  always_comb begin
    rd_req   = req_i & ~write_i;
    in_range = 32'(addr_i) < Depth;
    hit      = '0;
    flip     = '0;
    for (int i = 0; i < int'(NumFaults); i++) begin
      if (rd_req && armed_q[i] && (addr_i == ch_addr_q[i])) begin
        hit[i] = 1'b1;
        flip   = flip | ch_mask_q[i];
      end
    end
  end

  // Each mask bit enables a group of DataBitsPerMask data bits.
  always_comb begin
    bit_en = '0;
    for (int b = 0; b < int'(Width); b++) begin
      bit_en[b] = wmask_i[(b / int'(DataBitsPerMask)) * int'(DataBitsPerMask)];
    end
  end

  always_comb begin
    rd_word = '0;
    if (in_range) begin
      rd_word = mem[addr_i];
    end
  end

  // Channel next state: a config write overrides any consumption caused by this cycle's trigger.
  always_comb begin
    armed_d = '0;
    for (int i = 0; i < int'(NumFaults); i++) begin
      ch_addr_d[i] = ch_addr_q[i];
      ch_mask_d[i] = ch_mask_q[i];
      ch_mode_d[i] = ch_mode_q[i];
      ch_cnt_d[i]  = ch_cnt_q[i];
      if (hit[i]) begin
        case (ch_mode_q[i])
          ModeOneshot: ch_mode_d[i] = ModeOff;
          ModeCount:   ch_cnt_d[i]  = ch_cnt_q[i] - 8'd1;
          default:     ;
        endcase
      end
      if (flt_we_i && (32'(flt_idx_i) == 32'(i))) begin
        ch_addr_d[i] = flt_addr_i;
        ch_mask_d[i] = flt_mask_i;
        ch_mode_d[i] = mode_e'(flt_mode_i);
        ch_cnt_d[i]  = flt_cnt_i;
      end
      armed_d[i] = (ch_mode_d[i] != ModeOff) &&
                   ((ch_mode_d[i] != ModeCount) || (ch_cnt_d[i] != 8'd0));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      armed_q <= '0;
      for (int i = 0; i < int'(NumFaults); i++) begin
        ch_addr_q[i] <= '0;
        ch_mask_q[i] <= '0;
        ch_mode_q[i] <= ModeOff;
        ch_cnt_q[i]  <= '0;
      end
    end else begin
      armed_q <= armed_d;
      for (int i = 0; i < int'(NumFaults); i++) begin
        ch_addr_q[i] <= ch_addr_d[i];
        ch_mask_q[i] <= ch_mask_d[i];
        ch_mode_q[i] <= ch_mode_d[i];
        ch_cnt_q[i]  <= ch_cnt_d[i];
      end
    end
  end

  // Storage is never reset; out-of-range writes are dropped.
  always_ff @(posedge clk_i) begin
    if (req_i && write_i && in_range) begin
      mem[addr_i] <= (mem[addr_i] & ~bit_en) | (wdata_i & bit_en);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= rd_req;
      if (rd_req) begin
        s1_data_q <= rd_word ^ flip;
      end
    end
  end

  if (OutputReg != 0) begin : g_oreg
    logic             s2_valid_q;
    logic [Width-1:0] s2_data_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= s1_data_q;
        end
      end
    end

    assign rvalid_o = s2_valid_q;
    assign rdata_o  = s2_data_q;
  end else begin : g_noreg
    assign rvalid_o = s1_valid_q;
    assign rdata_o  = s1_data_q;
  end

  assign flt_armed_o = armed_q;

`ifdef PRIM_FAULT_RAM_STATS_EN
  logic [15:0] hits_q;

  // Counts reads that triggered at least one channel, saturating.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hits_q <= '0;
    end else if ((|hit) && (hits_q != 16'hFFFF)) begin
      hits_q <= hits_q + 16'd1;
    end
  end

  assign flt_hits_o = hits_q;
`endif

endmodule
